// File: rtl/time_counter.sv
// Time-of-day counter: BCD seconds/minutes/hours driven by a 1 Hz tick,
// with a three-state mode FSM for setting hours and minutes from two buttons.
module time_counter #(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic [1:0] mode,
    output logic       set_active
);

    localparam logic [7:0] HOUR_MAX_BCD = 8'(((HOUR_MAX / 10) * 16) + (HOUR_MAX % 10));
    localparam logic [7:0] SIXTY_M1_BCD = 8'h59;

    typedef enum logic [1:0] {
        NORMAL  = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hr_q,  hr_d;

    logic       tick_q, btn_mode_q, btn_inc_q;
    // Cleared by reset and set on the first clock afterwards, so a tick_in
    // that is already high when reset releases is not taken as an edge.
    logic       armed_q;

    logic       tick_ev, mode_ev, inc_ev;

    // Two-digit BCD increment; low digit 9 rolls into the high digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD increment that wraps to 00 at (or above) the given maximum; BCD
    // values compare correctly as plain binary since digits are ordered.
    function automatic logic [7:0] bcd_wrap_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max) begin
            return 8'h00;
        end
        return bcd_inc(v);
    endfunction

    assign tick_ev = tick_in  & ~tick_q & armed_q;
    assign mode_ev = btn_mode & ~btn_mode_q;
    assign inc_ev  = btn_inc  & ~btn_inc_q;

    // Registered copies of the inputs for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q     <= 1'b0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            tick_q     <= tick_in;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            armed_q    <= 1'b1;
        end
    end

    // Mode state and time-of-day registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NORMAL;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hr_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
        end
    end

    // Next state: a mode edge wins over tick and inc events in the same cycle.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        if (mode_ev) begin
            case (state_q)
                NORMAL: begin
                    state_d = SET_HR;
                    sec_d   = 8'h00;
                end
                SET_HR:  state_d = SET_MIN;
                default: state_d = NORMAL;
            endcase
        end else begin
            case (state_q)
                NORMAL: begin
                    if (tick_ev) begin
                        sec_d = bcd_wrap_inc(sec_q, SIXTY_M1_BCD);
                        if (sec_q >= SIXTY_M1_BCD) begin
                            min_d = bcd_wrap_inc(min_q, SIXTY_M1_BCD);
                            if (min_q >= SIXTY_M1_BCD) begin
                                hr_d = bcd_wrap_inc(hr_q, HOUR_MAX_BCD);
                            end
                        end
                    end
                end
                SET_HR: begin
                    if (inc_ev) begin
                        hr_d = bcd_wrap_inc(hr_q, HOUR_MAX_BCD);
                    end
                end
                SET_MIN: begin
                    if (inc_ev) begin
                        min_d = bcd_wrap_inc(min_q, SIXTY_M1_BCD);
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    assign sec_bcd    = sec_q;
    assign min_bcd    = min_q;
    assign hr_bcd     = hr_q;
    assign mode       = state_q;
    assign set_active = (state_q != NORMAL);

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: two instances (24-hour and 12-hour builds) share
// stimulus; a seconds-of-day model checks every cycle, plus literal checks.
module tb_time_counter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick_in = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;

    logic [7:0] sec_a, min_a, hr_a, sec_b, min_b, hr_b;
    logic [1:0] mode_a, mode_b;
    logic       sa_a, sa_b;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 is the HOUR_MAX=23 build, 1 the HOUR_MAX=11 build.
    int m_s [2];
    int m_m [2];
    int m_h [2];
    int m_md[2];
    int hmax[2] = '{23, 11};
    bit p_tick, p_mode, p_inc;

    always #5 clk = ~clk;

    time_counter #(.HOUR_MAX(23)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_bcd(sec_a), .min_bcd(min_a), .hr_bcd(hr_a), .mode(mode_a), .set_active(sa_a)
    );

    time_counter #(.HOUR_MAX(11)) dut12 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_bcd(sec_b), .min_bcd(min_b), .hr_bcd(hr_b), .mode(mode_b), .set_active(sa_b)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s[k] = 0; m_m[k] = 0; m_h[k] = 0; m_md[k] = 0;
        end
        // A tick level present at release must not count, so treat it as already seen.
        p_tick = 1'b1;
        p_mode = 1'b0;
        p_inc  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs the next edge will sample.
    task automatic model_step();
        bit te, me, ie;
        int total;
        te = tick_in && !p_tick;
        me = btn_mode && !p_mode;
        ie = btn_inc && !p_inc;
        for (int k = 0; k < 2; k++) begin
            if (me) begin
                if (m_md[k] == 0) m_s[k] = 0;
                m_md[k] = (m_md[k] + 1) % 3;
            end else if (m_md[k] == 0 && te) begin
                total = ((m_h[k] * 60 + m_m[k]) * 60 + m_s[k] + 1) % ((hmax[k] + 1) * 3600);
                m_h[k] = total / 3600;
                m_m[k] = (total / 60) % 60;
                m_s[k] = total % 60;
            end else if (m_md[k] == 1 && ie) begin
                m_h[k] = (m_h[k] + 1) % (hmax[k] + 1);
            end else if (m_md[k] == 2 && ie) begin
                m_m[k] = (m_m[k] + 1) % 60;
            end
        end
        p_tick = tick_in;
        p_mode = btn_mode;
        p_inc  = btn_inc;
    endtask

    task automatic compare_all();
        chk("sec24",  sec_a,  to_bcd(m_s[0]));
        chk("min24",  min_a,  to_bcd(m_m[0]));
        chk("hr24",   hr_a,   to_bcd(m_h[0]));
        chk("mode24", mode_a, m_md[0]);
        chk("set24",  sa_a,   (m_md[0] != 0) ? 1 : 0);
        chk("sec12",  sec_b,  to_bcd(m_s[1]));
        chk("min12",  min_b,  to_bcd(m_m[1]));
        chk("hr12",   hr_b,   to_bcd(m_h[1]));
        chk("mode12", mode_b, m_md[1]);
        chk("set12",  sa_b,   (m_md[1] != 0) ? 1 : 0);
    endtask

    // Inputs only change just after a rising edge, so at the falling edge they
    // are exactly what the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            compare_all();
            if (reset) model_step();
        end
    end

    task automatic cyc(input logic t, input logic m, input logic i);
        @(posedge clk);
        #1;
        tick_in  = t;
        btn_mode = m;
        btn_inc  = i;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; tick_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); end
    endtask

    task automatic inc_n(input int n);
        repeat (n) begin cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0); end
    endtask

    task automatic mode_p();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        do_reset();
        mode_p();
        inc_n(h);
        mode_p();
        inc_n(m);
        mode_p();
        tick_n(s);
    endtask

    task automatic lit_time(input string name, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk({name, "_hr"},  hr_a,  h);
        chk({name, "_min"}, min_a, m);
        chk({name, "_sec"}, sec_a, s);
    endtask

    initial begin
        // Reset state while reset is held low.
        repeat (3) @(posedge clk);
        #1;
        lit_time("rst", 8'h00, 8'h00, 8'h00);
        chk("rst_mode", mode_a, 0);
        chk("rst_set", sa_a, 0);
        reset = 1'b1;

        // Asynchronous reset mid-count at 12:34:56.
        set_time(12, 34, 56);
        lit_time("t123456", 8'h12, 8'h34, 8'h56);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        lit_time("async_rst", 8'h00, 8'h00, 8'h00);
        chk("async_rst_mode", mode_a, 0);
        chk("async_rst_set", sa_a, 0);

        // tick_in high across reset release is not a tick.
        tick_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("tick_at_release", sec_a, 8'h00);
        tick_in = 1'b0;
        tick_n(1);
        chk("tick_after_release", sec_a, 8'h01);

        // Frozen set mode from 10:20:30.
        set_time(10, 20, 30);
        mode_p();
        lit_time("enter_sethr", 8'h10, 8'h20, 8'h00);
        chk("sethr_mode", mode_a, 1);
        chk("sethr_set", sa_a, 1);
        tick_n(5);
        lit_time("frozen", 8'h10, 8'h20, 8'h00);

        // Coincident mode and inc edges in SET_HR at hour 05.
        do_reset();
        mode_p();
        inc_n(5);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("coinc_mode", mode_a, 2);
        chk("coinc_hr", hr_a, 8'h05);
        inc_n(60);
        chk("min_wrap_nocarry_min", min_a, 8'h00);
        chk("min_wrap_nocarry_hr", hr_a, 8'h05);

        // Hour wrap differs between 12- and 24-hour builds.
        do_reset();
        mode_p();
        inc_n(11);
        chk("hr11_24", hr_a, 8'h11);
        chk("hr11_12", hr_b, 8'h11);
        inc_n(1);
        chk("hrinc_24", hr_a, 8'h12);
        chk("hrinc_12", hr_b, 8'h00);

        // Full rollover.
        set_time(23, 59, 59);
        lit_time("t235959", 8'h23, 8'h59, 8'h59);
        chk("t115959_12", hr_b, 8'h11);
        tick_n(1);
        lit_time("rollover", 8'h00, 8'h00, 8'h00);
        chk("rollover_12", hr_b, 8'h00);

        // Digit carry with tick held high for 10 cycles.
        set_time(0, 0, 9);
        chk("sec09", sec_a, 8'h09);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("held_tick_sec", sec_a, 8'h10);
        chk("held_tick_min", min_a, 8'h00);

        // Tick coincident with mode edge in NORMAL.
        set_time(1, 2, 3);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("tick_mode_mode", mode_a, 1);
        chk("tick_mode_sec", sec_a, 8'h00);
        chk("tick_mode_min", min_a, 8'h02);

        // Randomized traffic, including occasional resets.
        do_reset();
        repeat (4000) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) reset = 1'b0;
            else if (!reset && $urandom_range(0, 2) == 0) reset = 1'b1;
            tick_in  = ($urandom_range(0, 1) == 1);
            btn_mode = ($urandom_range(0, 15) == 0);
            btn_inc  = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1; tick_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
